fpu_writeback: RTL and testbench

Registered result stage directly downstream of the combinational FPU core. Each cycle it may accept one completed operation. It selects the adder or mul/div result and its 5-bit IEEE flag vector, and formats single-precision results. It buffers up to two results behind a valid/ready handshake and maintains the sticky exception register (FPSR) and the trap indication at retirement.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fpu_wb_fifo.sv | 52 +++++
 rtl/fpu_writeback.sv | 81 ++++++++
 tb/tb_fpu_writeback.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU writeback stage: op codes, flag positions,
// the buffered entry layout and the NaN-box pattern for single results.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;

  localparam int FLG_INV = 4;
  localparam int FLG_DBZ = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  localparam int WB_TAGW = 5;

  localparam logic [31:0] NAN_BOX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [63:0]        result;
    logic [4:0]         flags;
    logic [WB_TAGW-1:0] tag;
  } wb_entry_t;

  // The reserved op code 3 is routed to the adder path.
  function automatic logic use_add_path(input logic [1:0] op);
    return (op == OP_ADD) || (op == 2'd3);
  endfunction

  // Single results occupy the upper word of the rounder output; box them.
  function automatic logic [63:0] format_result(input logic [63:0] sel, input logic db);
    return db ? sel : {NAN_BOX, sel[63:32]};
  endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Two-entry result buffer. Pushes into a full buffer and pops from an empty
// one are ignored, so the wrapper may drive push/pop from raw handshakes.
module fpu_wb_fifo
  import fpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output logic [1:0] count,
  output wb_entry_t head
);

  wb_entry_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      do_push;
  logic      do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  // Storage: cleared on reset so the visible head reads as zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_writeback.sv
// Result stage after the combinational FPU core: selects adder or mul/div
// output, NaN-boxes single results, buffers two entries and keeps the sticky
// exception flags (FPSR) plus an informational trap indication.
module fpu_writeback
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_db,
  input  logic [TAGW-1:0] in_tag,
  input  logic [63:0]     fp_add,
  input  logic [4:0]      ieee_add,
  input  logic [63:0]     fp_mul,
  input  logic [4:0]      ieee_mul,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_result,
  output logic [4:0]      out_flags,
  output logic [TAGW-1:0] out_tag,
  output logic            out_trap,
  input  logic [4:0]      trap_en,
  input  logic            fpsr_clr,
  output logic [4:0]      fpsr
);

  wb_entry_t  new_entry;
  wb_entry_t  head;
  logic [1:0] count;
  logic       accept;
  logic       retire;

  // Select and format the incoming operation into a buffer entry.
  always_comb begin
    new_entry = '0;
    if (use_add_path(in_op)) begin
      new_entry.result = format_result(fp_add, in_db);
      new_entry.flags  = ieee_add;
    end else begin
      new_entry.result = format_result(fp_mul, in_db);
      new_entry.flags  = ieee_mul;
    end
    new_entry.tag = in_tag;
  end

  // in_ready depends on registered occupancy only, never on out_ready.
  assign in_ready  = (32'(count) < DEPTH);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  fpu_wb_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (new_entry),
    .pop       (retire),
    .count     (count),
    .head      (head)
  );

  assign out_result = head.result;
  assign out_flags  = head.flags;
  assign out_tag    = head.tag;
  assign out_trap   = out_valid && (|(head.flags & trap_en));

  // Sticky flags: a clear in the retire cycle still records the retiring flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpsr <= 5'd0;
    end else begin
      fpsr <= (fpsr_clr ? 5'd0 : fpsr) | (retire ? head.flags : 5'd0);
    end
  end

endmodule

// File: tb/tb_fpu_writeback.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// each cycle against a queue-based model of the writeback stage.
module tb_fpu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_db;
  logic [4:0]  in_tag;
  logic [63:0] fp_add;
  logic [4:0]  ieee_add;
  logic [63:0] fp_mul;
  logic [4:0]  ieee_mul;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_flags;
  logic [4:0]  out_tag;
  logic        out_trap;
  logic [4:0]  trap_en;
  logic        fpsr_clr;
  logic [4:0]  fpsr;

  fpu_writeback #(.DEPTH(2), .TAGW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_db      (in_db),
    .in_tag     (in_tag),
    .fp_add     (fp_add),
    .ieee_add   (ieee_add),
    .fp_mul     (fp_mul),
    .ieee_mul   (ieee_mul),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_tag    (out_tag),
    .out_trap   (out_trap),
    .trap_en    (trap_en),
    .fpsr_clr   (fpsr_clr),
    .fpsr       (fpsr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  flags;
    logic [4:0]  tag;
  } mdl_entry_t;

  mdl_entry_t  mq[$];
  logic [4:0]  m_fpsr;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update for one rising edge, computed from the currently driven inputs.
  task automatic model_edge();
    mdl_entry_t e;
    logic [63:0] sel;
    bit acc, ret;
    acc = in_valid && (mq.size() < 2);
    ret = (mq.size() > 0) && out_ready;
    m_fpsr = (fpsr_clr ? 5'd0 : m_fpsr) | (ret ? mq[0].flags : 5'd0);
    if (ret) void'(mq.pop_front());
    if (acc) begin
      if (in_op == 2'd1 || in_op == 2'd2) begin
        sel = fp_mul; e.flags = ieee_mul;
      end else begin
        sel = fp_add; e.flags = ieee_add;
      end
      e.result = in_db ? sel : {32'hFFFF_FFFF, sel[63:32]};
      e.tag = in_tag;
      mq.push_back(e);
    end
  endtask

  task automatic compare_all();
    logic [4:0] hf;
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("fpsr", fpsr, m_fpsr);
    if (mq.size() > 0) begin
      hf = mq[0].flags;
      chk("out_result", out_result, mq[0].result);
      chk("out_flags", out_flags, hf);
      chk("out_tag", out_tag, mq[0].tag);
      chk("out_trap", out_trap, |(hf & trap_en));
    end else begin
      chk("out_trap_idle", out_trap, 1'b0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_op(input logic [1:0] op, input logic db, input logic [4:0] tag,
                        input logic [63:0] fa, input logic [4:0] fla,
                        input logic [63:0] fm, input logic [4:0] flm);
    in_valid = 1'b1; in_op = op; in_db = db; in_tag = tag;
    fp_add = fa; ieee_add = fla; fp_mul = fm; ieee_mul = flm;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_op = 0; in_db = 0; in_tag = 0;
    fp_add = 0; ieee_add = 0; fp_mul = 0; ieee_mul = 0;
    out_ready = 0; trap_en = 0; fpsr_clr = 0;
    m_fpsr = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_flags", out_flags, 5'd0);
    chk("rst_out_tag", out_tag, 5'd0);
    chk("rst_out_trap", out_trap, 1'b0);
    chk("rst_fpsr", fpsr, 5'd0);
    rst_n = 1'b1;

    // Double add passes through unchanged.
    set_op(2'd0, 1'b1, 5'd1, 64'h4000_0000_0000_0000, 5'd0, 64'h0, 5'h1F);
    step();
    chk("add_dbl_result", out_result, 64'h4000_0000_0000_0000);
    chk("add_dbl_flags", out_flags, 5'd0);
    in_valid = 0; out_ready = 1;
    step();
    chk("add_dbl_fpsr", fpsr, 5'd0);

    // Single mul is NaN-boxed.
    set_op(2'd1, 1'b0, 5'd7, 64'hDEAD_BEEF_0000_0000, 5'h1F, 64'h3F80_0000_0000_0000, 5'b00001);
    out_ready = 0;
    step();
    chk("mul_sgl_result", out_result, 64'hFFFF_FFFF_3F80_0000);
    chk("mul_sgl_tag", out_tag, 5'd7);
    in_valid = 0; out_ready = 1;
    step();
    chk("mul_sgl_fpsr", fpsr, 5'b00001);

    // Back-pressure: three back-to-back ops with out_ready low.
    out_ready = 0;
    set_op(2'd2, 1'b1, 5'd10, 64'h0, 5'd0, 64'h1111_1111_1111_1111, 5'd0);
    step();
    set_op(2'd3, 1'b1, 5'd11, 64'h2222_2222_2222_2222, 5'd0, 64'h0, 5'd0);
    step();
    chk("bp_in_ready_full", in_ready, 1'b0);
    set_op(2'd0, 1'b1, 5'd12, 64'h3333_3333_3333_3333, 5'd0, 64'h0, 5'd0);
    step();
    chk("bp_head_first", out_tag, 5'd10);
    out_ready = 1;
    step();
    chk("bp_head_second", out_tag, 5'd11);
    step();
    in_valid = 0;
    chk("bp_head_third", out_tag, 5'd12);
    step();
    step();

    // Clear in the retire cycle keeps the retiring flags.
    out_ready = 0;
    set_op(2'd0, 1'b1, 5'd3, 64'h0, 5'b01000, 64'h0, 5'd0);
    step();
    in_valid = 0; out_ready = 1; fpsr_clr = 1;
    step();
    fpsr_clr = 0;
    chk("clr_retire_fpsr", fpsr, 5'b01000);

    // Trap indication follows the enable mask combinationally.
    out_ready = 0;
    set_op(2'd1, 1'b1, 5'd4, 64'h0, 5'd0, 64'h5, 5'b10001);
    trap_en = 5'b10000;
    step();
    in_valid = 0;
    chk("trap_on", out_trap, 1'b1);
    trap_en = 5'd0;
    #1;
    chk("trap_off", out_trap, 1'b0);

    // Asynchronous reset with two entries buffered.
    set_op(2'd0, 1'b1, 5'd5, 64'h9, 5'b00100, 64'h0, 5'd0);
    step();
    in_valid = 0;
    chk("pre_rst_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_fpsr", fpsr, 5'd0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    mq.delete();
    m_fpsr = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_db     = 1'($urandom_range(0, 1));
      in_tag    = 5'($urandom);
      fp_add    = {$urandom, $urandom};
      fp_mul    = {$urandom, $urandom};
      ieee_add  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      ieee_mul  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      out_ready = ($urandom_range(0, 2) != 0);
      trap_en   = 5'($urandom);
      fpsr_clr  = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
